// File: rtl/button_event_decoder.sv
// -----------------------------------------------------------------------------
// button_event_decoder
//
// Turns the debounced switch level into discrete user events: press, release,
// single click, double click and long press. Every event output is a one-cycle
// registered pulse in the i_clk domain.
//
// Configuration macro:
//   BUTTON_EVENT_DOUBLE_CLICK_EN
//     defined   : double-click detection is built (GAP / PRESS2 states). A short
//                 press is reported as a single click only once the
//                 double-click window has expired.
//     undefined : GAP / PRESS2 are not built and o_double_click is tied low. A
//                 short press is reported as a single click together with its
//                 release, with no added latency.
//
// Parameters:
//   LONG_PRESS_CYCLES   : hold duration (cycles) that makes a long press (>= 2)
//   DOUBLE_CLICK_CYCLES : window after a release for the second press (>= 2)
//
// Ports:
//   i_clk          : system clock
//   i_rst_n        : asynchronous active-low reset
//   i_debounced    : debounced switch level, high = pressed, synchronous to i_clk
//   o_held         : registered copy of i_debounced
//   o_press        : pulse on each rising edge of the level
//   o_release      : pulse on each falling edge of the level
//   o_single_click : pulse when a short press is known not to start a double click
//   o_double_click : pulse when the second short press of a pair is released
//   o_long_press   : pulse when a hold reaches LONG_PRESS_CYCLES
// -----------------------------------------------------------------------------
module button_event_decoder #(
  parameter int LONG_PRESS_CYCLES   = 25000000,
  parameter int DOUBLE_CLICK_CYCLES = 6250000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_debounced,
  output logic o_held,
  output logic o_press,
  output logic o_release,
  output logic o_single_click,
  output logic o_double_click,
  output logic o_long_press
);

  localparam int MAX_CYCLES = (LONG_PRESS_CYCLES > DOUBLE_CLICK_CYCLES) ?
                              LONG_PRESS_CYCLES : DOUBLE_CLICK_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

  // The counter is cleared on the edge that enters a state, so it holds k-1 on
  // the k-th edge spent there; the terminal compare is therefore against N-1.
  localparam logic [CNT_W-1:0] LONG_TC = CNT_W'(LONG_PRESS_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};

`ifdef BUTTON_EVENT_DOUBLE_CLICK_EN
  localparam logic [CNT_W-1:0] GAP_TC = CNT_W'(DOUBLE_CLICK_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PRESS1    = 3'd1,
    ST_GAP       = 3'd2,
    ST_PRESS2    = 3'd3,
    ST_LONG_HELD = 3'd4
  } state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PRESS1    = 3'd1,
    ST_LONG_HELD = 3'd4
  } state_e;
`endif

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             r_prev_q, r_prev_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             single_q, single_d;
  logic             double_q, double_d;
  logic             long_q, long_d;

  logic             rise_s;
  logic             fall_s;
  logic             long_tc_s;

  // Edge detection against the previous sample; independent of FSM state.
  always_comb begin
    r_prev_d  = i_debounced;
    rise_s    = i_debounced & ~r_prev_q;
    fall_s    = ~i_debounced & r_prev_q;
    press_d   = rise_s;
    release_d = fall_s;
  end

  // Next-state and event decode. An edge sampled together with a terminal
  // count always takes priority over the timeout.
  always_comb begin
    state_d   = state_q;
    single_d  = 1'b0;
    double_d  = 1'b0;
    long_d    = 1'b0;
    long_tc_s = (cnt_q == LONG_TC);

    case (state_q)
      ST_IDLE: begin
        if (rise_s) begin
          state_d = ST_PRESS1;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_PRESS1: begin
        if (fall_s) begin
`ifdef BUTTON_EVENT_DOUBLE_CLICK_EN
          state_d = ST_GAP;
`else
          state_d  = ST_IDLE;
          single_d = 1'b1;
`endif
        end else if (long_tc_s) begin
          state_d = ST_LONG_HELD;
          long_d  = 1'b1;
        end else begin
          state_d = ST_PRESS1;
        end
      end

`ifdef BUTTON_EVENT_DOUBLE_CLICK_EN
      ST_GAP: begin
        if (rise_s) begin
          state_d = ST_PRESS2;
        end else if (cnt_q == GAP_TC) begin
          state_d  = ST_IDLE;
          single_d = 1'b1;
        end else begin
          state_d = ST_GAP;
        end
      end

      ST_PRESS2: begin
        if (fall_s) begin
          state_d  = ST_IDLE;
          double_d = 1'b1;
        end else if (long_tc_s) begin
          // A long second press swallows the click entirely.
          state_d = ST_LONG_HELD;
          long_d  = 1'b1;
        end else begin
          state_d = ST_PRESS2;
        end
      end
`endif

      ST_LONG_HELD: begin
        if (fall_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_LONG_HELD;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Shared cycle counter: cleared on every state change, saturates at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (cnt_q != CNT_SAT) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State, counter and registered event outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= {CNT_W{1'b0}};
      r_prev_q  <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      single_q  <= 1'b0;
      double_q  <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      r_prev_q  <= r_prev_d;
      press_q   <= press_d;
      release_q <= release_d;
      single_q  <= single_d;
      double_q  <= double_d;
      long_q    <= long_d;
    end
  end

  assign o_held         = r_prev_q;
  assign o_press        = press_q;
  assign o_release      = release_q;
  assign o_single_click = single_q;
  assign o_double_click = double_q;
  assign o_long_press   = long_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// -----------------------------------------------------------------------------
// Testbench for button_event_decoder (LONG_PRESS_CYCLES=20, DOUBLE_CLICK_CYCLES=10).
// Each table entry describes a level waveform (up to two high segments) and the
// steps at which each event pulse must appear. Expected output vectors are
// pushed to a scoreboard queue as each input step is driven and popped/compared
// one clock later. Hand-written sequences cover reset behaviour.
// Expected values follow the build: with BUTTON_EVENT_DOUBLE_CLICK_EN defined
// single clicks wait for the double-click window; otherwise they coincide with
// the release.
// -----------------------------------------------------------------------------
module tb_button_event_decoder;

  localparam int LP = 20;
  localparam int DC = 10;
  localparam int NV = 9;

  logic clk = 1'b0;
  logic rst_n;
  logic deb;
  logic o_held, o_press, o_release, o_single_click, o_double_click, o_long_press;

  always #5 clk = ~clk;

  button_event_decoder #(
    .LONG_PRESS_CYCLES  (LP),
    .DOUBLE_CLICK_CYCLES(DC)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_debounced   (deb),
    .o_held        (o_held),
    .o_press       (o_press),
    .o_release     (o_release),
    .o_single_click(o_single_click),
    .o_double_click(o_double_click),
    .o_long_press  (o_long_press)
  );

  // Waveform: high for h1 steps from step a, low for g steps, high for h2 steps,
  // then low until step total-1. Event fields hold the step whose following
  // cycle carries the pulse; -1 means no such pulse.
  typedef struct {
    int a; int h1; int g; int h2; int total;
    int pr_a; int pr_b; int rl_a; int rl_b;
    int sc_a; int sc_b; int dc; int lp;
  } vec_t;

  typedef struct {
    logic [5:0] exp;
    int         scen;
    int         step;
  } sb_t;

  vec_t  vecs [NV];
  string names[NV+1];
  sb_t   sb_q[$];
  int    n_checks = 0;
  int    n_errors = 0;

  function automatic vec_t mk(int a, int h1, int g, int h2, int total,
                              int pr_a, int pr_b, int rl_a, int rl_b,
                              int sc_a, int sc_b, int dcl, int lpr);
    vec_t v;
    v.a = a; v.h1 = h1; v.g = g; v.h2 = h2; v.total = total;
    v.pr_a = pr_a; v.pr_b = pr_b; v.rl_a = rl_a; v.rl_b = rl_b;
    v.sc_a = sc_a; v.sc_b = sc_b; v.dc = dcl; v.lp = lpr;
    return v;
  endfunction

  function automatic logic lvl_at(vec_t v, int k);
    logic hi1, hi2;
    hi1 = (k >= v.a) && (k < v.a + v.h1);
    hi2 = (v.h2 > 0) && (k >= v.a + v.h1 + v.g) && (k < v.a + v.h1 + v.g + v.h2);
    return hi1 | hi2;
  endfunction

  // {held, press, release, single, double, long}
  function automatic logic [5:0] exp_at(vec_t v, int k);
    logic [5:0] e;
    e[5] = lvl_at(v, k);
    e[4] = (k == v.pr_a) || (k == v.pr_b);
    e[3] = (k == v.rl_a) || (k == v.rl_b);
    e[2] = (k == v.sc_a) || (k == v.sc_b);
    e[1] = (k == v.dc);
    e[0] = (k == v.lp);
    return e;
  endfunction

  function automatic logic [5:0] dut_vec();
    return {o_held, o_press, o_release, o_single_click, o_double_click, o_long_press};
  endfunction

  task automatic check_pending();
    sb_t        e;
    logic [5:0] got;
    if (sb_q.size() > 0) begin
      e   = sb_q.pop_front();
      got = dut_vec();
      n_checks++;
      if (got !== e.exp) begin
        n_errors++;
        $display("FAIL %s step %0d: got %b expected %b (held,press,release,single,double,long)",
                 names[e.scen], e.step, got, e.exp);
      end
    end
  endtask

  task automatic check_zero(string nm);
    logic [5:0] got;
    got = dut_vec();
    n_checks++;
    if (got !== 6'b000000) begin
      n_errors++;
      $display("FAIL %s: got %b expected 000000", nm, got);
    end
  endtask

  task automatic drive_step(int s, int k);
    sb_t e;
    @(negedge clk);
    check_pending();
    deb    = lvl_at(vecs[s], k);
    e.exp  = exp_at(vecs[s], k);
    e.scen = s;
    e.step = k;
    sb_q.push_back(e);
  endtask

  task automatic run_scen(int s, int first_k);
    for (int k = first_k; k < vecs[s].total; k++) begin
      drive_step(s, k);
    end
  endtask

  task automatic flush();
    @(negedge clk);
    check_pending();
  endtask

  initial begin
    sb_t e;

    names[0] = "reset_release";
    names[1] = "short_press";
    names[2] = "double_click";
    names[3] = "long_hold";
    names[4] = "release_at_long_tc";
    names[5] = "press_at_gap_tc";
    names[6] = "press_after_gap";
    names[7] = "long_second_press";
    names[8] = "mid_gap_prefix";
    names[9] = "after_mid_gap_reset";

`ifdef BUTTON_EVENT_DOUBLE_CLICK_EN
    vecs[0] = mk(0,  3, 15,  0, 18,  0, -1,  3, -1, 13, -1, -1, -1);
    vecs[1] = mk(1,  5, 19,  0, 25,  1, -1,  6, -1, 16, -1, -1, -1);
    vecs[2] = mk(1,  5,  4,  5, 30,  1, 10,  6, 15, -1, -1, 15, -1);
    vecs[3] = mk(1, 30,  0,  0, 40,  1, -1, 31, -1, -1, -1, -1, 21);
    vecs[4] = mk(1, 20,  0,  0, 40,  1, -1, 21, -1, 31, -1, -1, -1);
    vecs[5] = mk(1,  5, 10,  5, 35,  1, 16,  6, 21, -1, -1, 21, -1);
    vecs[6] = mk(1,  5, 11,  5, 40,  1, 17,  6, 22, 16, 32, -1, -1);
    vecs[7] = mk(1,  5,  3, 25, 40,  1,  9,  6, 34, -1, -1, -1, 29);
    vecs[8] = mk(1,  5, 20,  0,  9,  1, -1,  6, -1, -1, -1, -1, -1);
`else
    vecs[0] = mk(0,  3, 15,  0, 18,  0, -1,  3, -1,  3, -1, -1, -1);
    vecs[1] = mk(1,  5, 19,  0, 25,  1, -1,  6, -1,  6, -1, -1, -1);
    vecs[2] = mk(1,  5,  4,  5, 30,  1, 10,  6, 15,  6, 15, -1, -1);
    vecs[3] = mk(1, 30,  0,  0, 40,  1, -1, 31, -1, -1, -1, -1, 21);
    vecs[4] = mk(1, 20,  0,  0, 40,  1, -1, 21, -1, 21, -1, -1, -1);
    vecs[5] = mk(1,  5, 10,  5, 35,  1, 16,  6, 21,  6, 21, -1, -1);
    vecs[6] = mk(1,  5, 11,  5, 40,  1, 17,  6, 22,  6, 22, -1, -1);
    vecs[7] = mk(1,  5,  3, 25, 40,  1,  9,  6, 34,  6, -1, -1, 29);
    vecs[8] = mk(1,  5, 20,  0,  9,  1, -1,  6, -1,  6, -1, -1, -1);
`endif

    // Reset held with the button pressed: everything stays low.
    rst_n = 1'b0;
    deb   = 1'b1;
    repeat (3) @(negedge clk);
    check_zero("reset_hold_a");
    @(negedge clk);
    check_zero("reset_hold_b");

    // Release reset; the first edge afterwards sees the held level as a rise.
    rst_n  = 1'b1;
    deb    = lvl_at(vecs[0], 0);
    e.exp  = exp_at(vecs[0], 0);
    e.scen = 0;
    e.step = 0;
    sb_q.push_back(e);
    run_scen(0, 1);

    for (int s = 1; s < NV; s++) begin
      run_scen(s, 0);
    end
    flush();

    // Reset asserted in the middle of the double-click window.
    rst_n = 1'b0;
    #1;
    check_zero("mid_gap_reset_async");
    @(negedge clk);
    check_zero("mid_gap_reset_hold");
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check_pending();
      deb    = 1'b0;
      e.exp  = 6'b000000;
      e.scen = 9;
      e.step = k;
      sb_q.push_back(e);
    end
    flush();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/button_event_decoder.md
# button_event_decoder

Classifies the debounced switch level into discrete user events: press, release, single click, double click and long press. It sits directly downstream of the debounce filter, replacing raw edge detection for consumers such as LED toggling or mode selection. All event outputs are one-cycle, registered pulses in the `i_clk` domain.

## Interface
- `LONG_PRESS_CYCLES`, default 25000000: hold duration, in cycles, that qualifies as a long press (1 s at 25 MHz); must be ≥ 2.
- `DOUBLE_CLICK_CYCLES`, default 6250000: window after a release in which a second press forms a double click (250 ms at 25 MHz); must be ≥ 2.
- `i_clk` input 1: system clock; one clock domain only.
- `i_rst_n` input 1: asynchronous, active-low reset.
- `i_debounced` input 1: debounced switch level, high = pressed; already synchronous to `i_clk`.
- `o_held` output 1: registered copy of `i_debounced`.
- `o_press` output 1: pulse on each rising edge of the level.
- `o_release` output 1: pulse on each falling edge of the level.
- `o_single_click` output 1: pulse when a short press is confirmed not to be part of a double click.
- `o_double_click` output 1: pulse when the second short press of a pair is released.
- `o_long_press` output 1: pulse when a hold reaches `LONG_PRESS_CYCLES`.

## Operation
- Edge detection:
  - The previous sample is held in `r_prev`, which resets to 0. A level held high through reset therefore produces `o_press` one cycle after reset deasserts.
  - `o_press` and `o_release` fire on every edge, independent of FSM state.
- One shared cycle counter, width `$clog2(max(LONG_PRESS_CYCLES, DOUBLE_CLICK_CYCLES))+1`. It is cleared on every state change and saturates rather than wrapping.
- FSM states: IDLE, PRESS1, GAP, PRESS2, LONG_HELD. Transitions:
  - IDLE: on rise → PRESS1.
  - PRESS1:
    - on fall → GAP;
    - when the hold count reaches `LONG_PRESS_CYCLES` → pulse `o_long_press`, go to LONG_HELD.
  - GAP:
    - on rise → PRESS2;
    - when the count reaches `DOUBLE_CLICK_CYCLES` → pulse `o_single_click`, go to IDLE.
  - PRESS2:
    - on fall → pulse `o_double_click`, go to IDLE;
    - when the hold count reaches `LONG_PRESS_CYCLES` → pulse `o_long_press`, go to LONG_HELD. No click is reported in this case.
  - LONG_HELD: on fall → IDLE. No click is reported.
- Simultaneous events:
  - A fall sampled on the same edge as the long-press terminal count wins: no `o_long_press`, and the normal click path is taken.
  - A rise sampled on the same edge as the GAP terminal count wins: go to PRESS2, no `o_single_click`.
- Triple presses: a rise in IDLE right after a double click starts a new sequence.
- At most one of `o_single_click`, `o_double_click`, `o_long_press` is high in any cycle.
- Reset mid-operation: FSM returns to IDLE, counter clears, all outputs drop to 0 asynchronously. No pending event is emitted afterwards.

## Timing
- Reset values: every output is 0; `r_prev` = 0; state is IDLE.
- Edge-pulse latency:
  - A change on `i_debounced` sampled at edge N drives `o_held`, `o_press` / `o_release` high for the cycle following edge N.
  - Each pulse lasts exactly 1 cycle.
- Long press: with `o_press` high in cycle T and the level held continuously, `o_long_press` is high in cycle T+`LONG_PRESS_CYCLES`.
- Single click: with `o_release` high in cycle R and no further press, `o_single_click` is high in cycle R+`DOUBLE_CLICK_CYCLES`.
- Double click: `o_double_click` is high in the same cycle as the second `o_release`.

## Configuration
- `BUTTON_EVENT_DOUBLE_CLICK_EN` defined (the default build): full behaviour as described above.
- Undefined:
  - The GAP and PRESS2 states are not built, and `o_double_click` is tied to 0.
  - A short press releases from PRESS1 straight to IDLE, with `o_single_click` coincident with `o_release`; there is no added latency.
  - `o_long_press` is unchanged.

## Test plan
All scenarios use `LONG_PRESS_CYCLES`=20, `DOUBLE_CLICK_CYCLES`=10.
- Reset: hold `i_rst_n`=0 with `i_debounced`=1 → all outputs 0; release reset → `o_press` in the 1st cycle after deassertion.
- Short press of 5 cycles, then idle → `o_press` at T, `o_release` at T+5, `o_single_click` at T+15; no other events.
- Two presses of 5 cycles separated by a 4-cycle gap → a single `o_double_click` coincident with the second `o_release`; no `o_single_click`.
- Hold for 30 cycles → `o_long_press` at T+20; `o_release` at T+30; no click pulse. Also release exactly at T+20 → no `o_long_press`, `o_single_click` at T+30.
- Press sampled exactly 10 cycles after the first release → PRESS2 is entered, no `o_single_click`; releasing then gives `o_double_click`. Separately, assert reset mid-GAP → no pulse follows.
- With the macro undefined: a 5-cycle press → `o_single_click` coincident with `o_release`, and `o_double_click` never asserts.
